// File: rtl/mac_pkg.sv
// mac_pkg: shared defaults, derived widths and state encoding for the MAC accumulate stage
//   DEF_M, DEF_N   : operand widths of the upstream multiplier
//   DEF_G          : guard bits above the product width
//   DEF_CNT_W      : term-counter width
//   PROD_W, ACC_W  : product and accumulator widths derived from the defaults
package mac_pkg;
    localparam int DEF_M     = 6;
    localparam int DEF_N     = 4;
    localparam int DEF_G     = 4;
    localparam int DEF_CNT_W = 8;
    localparam int PROD_W    = DEF_M + DEF_N;
    localparam int ACC_W     = DEF_M + DEF_N + DEF_G;
    typedef enum logic {ACC, DONE} state_t;
endpackage

// File: rtl/mac_accumulator_if.sv
// mac_accumulator_if: product input stream and frame result stream of the accumulate stage
//   in_valid/in_ready/in_prod/in_last          : product stream from the multiplier
//   out_valid/out_ready/out_sum/out_count/out_overflow : frame result stream
//   slave  : the accumulator side
//   master : the producer/consumer side (multiplier and downstream)
interface mac_accumulator_if
    import mac_pkg::*;
#(
    parameter int PW = PROD_W,
    parameter int AW = ACC_W,
    parameter int CW = DEF_CNT_W
);
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_prod;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic [CW-1:0] out_count;
    logic          out_overflow;

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_overflow
    );

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_overflow
    );
endinterface

// File: rtl/mac_sat_adder.sv
// mac_sat_adder: unsigned saturating add of a product into an accumulator
//   acc  : current accumulator value (ACC_W bits)
//   prod : unsigned product, zero-extended to ACC_W (PROD_W bits)
//   sum  : acc + prod, clamped to all-ones on overflow
//   sat  : high when the clamp was applied
module mac_sat_adder
    import mac_pkg::*;
#(
    parameter int ACC_W  = mac_pkg::ACC_W,
    parameter int PROD_W = mac_pkg::PROD_W
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              sat
);
    logic [ACC_W:0] full;

    // One extra bit catches the carry out of the accumulator width.
    assign full = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    assign sat  = full[ACC_W];
    assign sum  = sat ? '1 : full[ACC_W-1:0];
endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: frame accumulator behind the M x N multiplier
//   clk   : clock, all state on rising edge
//   rst   : synchronous active-high reset
//   clear : synchronous abort of the partial sum or pending result
//   bus   : product input and frame result streams (slave side)
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int M     = DEF_M,
    parameter int N     = DEF_N,
    parameter int G     = DEF_G,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    mac_accumulator_if.slave  bus
);
    localparam int PW = M + N;
    localparam int AW = M + N + G;

    state_t           state, state_n;
    logic [AW-1:0]    acc, acc_n, sum_q;
    logic [CNT_W-1:0] cnt, cnt_n, count_q;
    logic             ovf, ovf_n, ovf_q, sat, take;

    mac_sat_adder #(.ACC_W(AW), .PROD_W(PW)) u_add (
        .acc  (acc),
        .prod (bus.in_prod),
        .sum  (acc_n),
        .sat  (sat)
    );

    // Handshake flags decode state only, so no input reaches them combinationally.
    assign bus.in_ready     = state == ACC;
    assign bus.out_valid    = state == DONE;
    assign bus.out_sum      = sum_q;
    assign bus.out_count    = count_q;
    assign bus.out_overflow = ovf_q;

    assign take  = bus.in_ready && bus.in_valid;
    assign ovf_n = ovf || sat;
    assign cnt_n = &cnt ? cnt : cnt + 1'b1;

    always_comb begin
        state_n = clear ? ACC
                : state == ACC ? ((take && bus.in_last) ? DONE : ACC)
                : (bus.out_ready ? ACC : DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ACC;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            sum_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state <= state_n;
            if (clear) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else if (take && bus.in_last) begin
                // Publish the frame and restart the running sum for the next one.
                sum_q   <= acc_n;
                count_q <= cnt_n;
                ovf_q   <= ovf_n;
                acc     <= '0;
                cnt     <= '0;
                ovf     <= 1'b0;
            end else if (take) begin
                acc <= acc_n;
                cnt <= cnt_n;
                ovf <= ovf_n;
            end
        end
    end
endmodule
